test: RTL and testbench
=======================

Name: test

Overview:
- Switch-to-LED indicator controller for the Artix-7 board bring-up design.
- Takes five asynchronous switch/button inputs (a..e) and drives four LEDs (l0..l3).
- Input a is the master enable; b, c, d, e qualify progressively higher indication levels; l2 supports solid and blinking modes.
- All inputs are synchronized, decoded and driven through registered outputs in a single clock domain.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages per input (minimum 2).
- BLINK_HALF, 50_000_000, clock cycles per blink half-period (on time = off time); minimum 1.
- CNT_W, $clog2(BLINK_HALF+1), blink counter width (derived, not overridden).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, reset, synchronous, active-low.
- a, input, 1, master enable switch, asynchronous.
- b, input, 1, qualifier switch, asynchronous.
- c, input, 1, qualifier switch, asynchronous.
- d, input, 1, solid-level switch, asynchronous.
- e, input, 1, blink-request switch, asynchronous.
- l0, output, 1, LED0: enabled indicator.
- l1, output, 1, LED1: qualified indicator.
- l2, output, 1, LED2: solid or blinking level indicator.
- l3, output, 1, LED3: activity-while-disabled warning.

Behaviour:
- Reset: when rst_n=0 at a rising clk, all synchronizer flops, the blink counter, the blink phase and l0..l3 are cleared to 0. Reset overrides all other activity, including mid-blink.
- Synchronization: each input passes through a SYNC_STAGES flop chain. The synchronized values are sa..se. There is no debounce.
- Decode (combinational on synchronized inputs):
  - on0 = sa
  - on1 = sa & sb & sc
  - solid2 = on1 & sd
  - blink_mode = on1 & ~sd & se
  - on3 = ~sa & (sb | sc | sd | se)
- d has priority over e: if both are 1, l2 is solid.
- Blink generator:
  - Counter runs only while blink_mode=1.
  - On the first cycle blink_mode is asserted, the counter loads 0 and the phase is set to 1, so the LED turns on immediately.
  - When the counter reaches BLINK_HALF-1, it wraps to 0 and the phase toggles. Otherwise it increments by 1.
  - When blink_mode=0, the counter is held at 0 and the phase at 0.
  - Each blink_mode entry restarts the pattern at phase 1.
- Outputs are registered and updated every clk:
  - l0 <= on0
  - l1 <= on1
  - l2 <= solid2 | (blink_mode & phase)
  - l3 <= on3
- Latency: an input change reaches the LED SYNC_STAGES+1 clock edges later; the blink phase adds no extra delay.
- Output combinations:
  - With a=0, l0, l1 and l2 are 0 regardless of b..e.
  - With a=1, l3 is 0.
  - All inputs 0 gives all LEDs 0.
- Glitch freedom: inputs pulsing shorter than one clk may be missed; no latching of short pulses.

Test Plan:
- All inputs 0, rst_n released after 5 cycles -> l0..l3 = 0 throughout.
- a=1 only -> l0=1 after SYNC_STAGES+1 edges; l1=l2=l3=0.
- a=b=c=1 -> l0=l1=1, l2=0; then d=1 -> l2=1 solid and constant over 3×BLINK_HALF cycles.
- Blink mode, with BLINK_HALF=4: a=b=c=e=1, d=0 (d falls one cycle before e rises) -> l2 alternates 4 cycles on / 4 cycles off, starting on. Then set d=1 -> l2 solid 1. Then clear d -> blink restarts with the on phase.
- Disabled warning: from a=b=c=e=1, d=0, set a=0 -> l0=l1=l2=0 and l3=1 after latency. Then clear b,c,e -> l3=0.
- Reset mid-blink: assert rst_n=0 for 1 cycle during the l2 on-phase -> all outputs 0 on the next edge. After release, blink resumes with a full on-phase after latency.

Source files
------------

// File: rtl/test.sv
// Switch-to-LED indicator controller.
//
// Five asynchronous switch inputs are synchronized and decoded to drive four
// registered LEDs in a single clock domain.
//   - a is the master enable.
//   - b and c qualify the next level.
//   - d selects a solid level on l2.
//   - e requests a blinking level on l2. If d and e are both 1, d wins.
//
// Ports:
//   clk     rising-edge system clock
//   rst_n   synchronous, active-low reset; clears all state
//   a..e    asynchronous switch inputs
//   l0      enabled indicator
//   l1      qualified indicator
//   l2      solid/blinking level indicator
//   l3      warning: some switch is active while the controller is disabled
//
// Latency from an input change to the LED is SYNC_STAGES+1 clock edges.
module test #(
  parameter  int SYNC_STAGES = 2,
  parameter  int BLINK_HALF  = 50_000_000,
  localparam int CNT_W       = $clog2(BLINK_HALF + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  output logic l0,
  output logic l1,
  output logic l2,
  output logic l3
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  // Stage p0: synchronizer chains, one 5-bit lane per stage.
  // Bit order is {e, d, c, b, a}.
  logic [SYNC_STAGES-1:0][4:0] sync_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0[0] <= {e, d, c, b, a};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_p0[i] <= sync_p0[i-1];
      end
    end
  end

  logic sa, sb, sc, sd, se;
  assign {se, sd, sc, sb, sa} = sync_p0[SYNC_STAGES-1];

  // Decode of the synchronized switch levels.
  logic on0, on1, solid2, blink_mode, on3;
  assign on0        = sa;
  assign on1        = sa & sb & sc;
  assign solid2     = on1 & sd;
  assign blink_mode = on1 & ~sd & se;
  assign on3        = ~sa & (sb | sc | sd | se);

  // Stage p1: blink generator.
  // The next phase is computed combinationally and fed straight into the l2
  // register. As a result, blink entry lights the LED on the same edge that a
  // solid level would, without an extra cycle of delay.
  // blink_prev_p1 detects a fresh entry into blink mode. Every entry
  // restarts the pattern with a full on-phase.
  logic [CNT_W-1:0] cnt_p1, cnt_nxt;
  logic             phase_p1, phase_nxt;
  logic             blink_prev_p1;

  always_comb begin
    cnt_nxt   = cnt_p1;
    phase_nxt = phase_p1;
    if (!blink_mode) begin
      cnt_nxt   = '0;
      phase_nxt = 1'b0;
    end else if (!blink_prev_p1) begin
      cnt_nxt   = '0;
      phase_nxt = 1'b1;
    end else if (cnt_p1 == CNT_LAST) begin
      cnt_nxt   = '0;
      phase_nxt = ~phase_p1;
    end else begin
      cnt_nxt   = cnt_p1 + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p1        <= '0;
      phase_p1      <= 1'b0;
      blink_prev_p1 <= 1'b0;
    end else begin
      cnt_p1        <= cnt_nxt;
      phase_p1      <= phase_nxt;
      blink_prev_p1 <= blink_mode;
    end
  end

  // Stage p2: registered LED outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l0 <= 1'b0;
      l1 <= 1'b0;
      l2 <= 1'b0;
      l3 <= 1'b0;
    end else begin
      l0 <= on0;
      l1 <= on1;
      l2 <= solid2 | (blink_mode & phase_nxt);
      l3 <= on3;
    end
  end

endmodule

// File: tb/tb_test.sv
// Directed testbench for the switch-to-LED controller.
// Built with SYNC_STAGES=2 and BLINK_HALF=4, so outputs follow inputs
// 3 edges later.
// Inputs are driven on the falling edge.
// Outputs are sampled on the falling edge as {l3, l2, l1, l0}.
module tb_test;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c, d, e;
  logic l0, l1, l2, l3;

  int n_cmp = 0;
  int n_bad = 0;

  test #(.SYNC_STAGES(2), .BLINK_HALF(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .l0    (l0),
    .l1    (l1),
    .l2    (l2),
    .l3    (l3)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] leds();
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {a, b, c, d, e} = '0;

    // Reset with all inputs low, then release.
    step(5);
    check("reset", leds(), 4'b0000);
    rst_n = 1'b1;
    step(4);
    check("idle", leds(), 4'b0000);

    // a only: l0 rises exactly 3 edges later.
    a = 1'b1;
    step(2);
    check("a_lat2", leds(), 4'b0000);
    step(1);
    check("a_lat3", leds(), 4'b0001);

    // Qualified level.
    b = 1'b1;
    c = 1'b1;
    step(3);
    check("abc", leds(), 4'b0011);

    // Solid l2, held constant over 3 x BLINK_HALF cycles.
    d = 1'b1;
    step(3);
    check("solid", leds(), 4'b0111);
    for (int i = 0; i < 12; i++) begin
      step(1);
      check($sformatf("solid_hold%0d", i), leds(), 4'b0111);
    end

    // Blink: d falls one cycle before e rises.
    // l2 is then on for 4 cycles, off for 4 cycles, and repeats.
    d = 1'b0;
    step(1);
    e = 1'b1;
    step(2);
    check("blink_gap", leds(), 4'b0011);
    for (int i = 0; i < 16; i++) begin
      step(1);
      check($sformatf("blink%0d", i), leds(), ((i / 4) % 2 == 0) ? 4'b0111 : 4'b0011);
    end

    // d overrides e: solid again.
    d = 1'b1;
    step(3);
    check("d_over_e", leds(), 4'b0111);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check($sformatf("d_over_e%0d", i), leds(), 4'b0111);
    end

    // Clearing d restarts the blink with the on-phase.
    d = 1'b0;
    step(3);
    check("reblink0", leds(), 4'b0111);
    for (int i = 1; i < 8; i++) begin
      step(1);
      check($sformatf("reblink%0d", i), leds(), (i < 4) ? 4'b0111 : 4'b0011);
    end

    // Disabled warning while other switches remain active.
    a = 1'b0;
    step(3);
    check("warn", leds(), 4'b1000);
    b = 1'b0;
    c = 1'b0;
    step(2);
    check("warn_e", leds(), 4'b1000);
    e = 1'b0;
    step(3);
    check("warn_clr", leds(), 4'b0000);

    // Reset during the on-phase of a blink.
    a = 1'b1;
    b = 1'b1;
    c = 1'b1;
    e = 1'b1;
    step(3);
    check("rblink0", leds(), 4'b0111);
    step(1);
    check("rblink1", leds(), 4'b0111);
    rst_n = 1'b0;
    step(1);
    check("mid_reset", leds(), 4'b0000);
    rst_n = 1'b1;
    step(2);
    check("post_rst_lat", leds(), 4'b0000);
    step(1);
    check("post_rst0", leds(), 4'b0111);
    for (int i = 1; i < 8; i++) begin
      step(1);
      check($sformatf("post_rst%0d", i), leds(), (i < 4) ? 4'b0111 : 4'b0011);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
